// File: rtl/load_register.sv
// Clock-enabled holding register for the CPU datapath.
// Captures data_in on a rising edge when load is high; rst clears it asynchronously.
module load_register #(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DataWidth-1:0] data_in,
  output logic [DataWidth-1:0] data_out
);

  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Output comes straight from the flops; no path from inputs.
  assign data_out = data_q;

endmodule

// File: tb/tb_load_register.sv
// Scoreboard bench for load_register: driver pushes expected values,
// monitor pops and compares at each falling edge or on an async-reset probe.
module tb_load_register;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] model;
  logic         async_tick;
  logic         driver_done;
  int           checks;
  int           failures;

  load_register #(.DataWidth(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive after the falling edge, predict at the rising edge.
  task automatic cycle(input logic r, input logic l, input logic [W-1:0] d, input string nm);
    @(negedge clk);
    #1;
    rst     = r;
    load    = l;
    data_in = d;
    @(posedge clk);
    if (r)      model = '0;
    else if (l) model = d;
    exp_q.push_back(model);
    name_q.push_back(nm);
  endtask

  // Monitor
  initial begin
    logic [W-1:0] e;
    string        nm;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk or async_tick);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (data_out !== e) begin
          failures++;
          $display("FAIL %s: data_out=%h expected=%h at t=%0t", nm, data_out, e, $time);
        end
      end
    end
  end

  // Driver
  initial begin
    logic         r, l;
    logic [W-1:0] d;
    driver_done = 1'b0;
    async_tick  = 1'b0;
    model       = '0;
    rst         = 1'b1;
    load        = 1'b1;
    data_in     = 8'hFF;

    cycle(1'b1, 1'b1, 8'hFF, "reset_state");
    cycle(1'b1, 1'b0, 8'h12, "reset_hold");
    cycle(1'b0, 1'b1, 8'h55, "load_55");
    cycle(1'b0, 1'b1, 8'hAA, "b2b_AA");
    cycle(1'b0, 1'b1, 8'hFF, "load_FF");
    cycle(1'b1, 1'b1, 8'hFF, "rst_over_load");
    cycle(1'b0, 1'b1, 8'h3C, "load_3C");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'hC3, "hold_3C");
    cycle(1'b0, 1'b1, 8'h5A, "load_5A");

    // Asynchronous clear between edges, clk stable.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model = '0;
    exp_q.push_back(model);
    name_q.push_back("async_clear");
    async_tick = ~async_tick;
    cycle(1'b0, 1'b1, 8'h81, "load_after_rst");
    cycle(1'b0, 1'b0, 8'h00, "hold_81");
    cycle(1'b0, 1'b1, 8'h00, "load_zero");
    cycle(1'b0, 1'b1, 8'h01, "load_01");
    cycle(1'b0, 1'b1, 8'h80, "load_80");

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(15) == 0);
      l = $urandom_range(1);
      d = W'($urandom);
      cycle(r, l, d, "random");
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    driver_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (driver_done);
      end
      begin
        #100000;
        checks++;
        failures++;
        $display("FAIL timeout: driver_done=0 expected=1");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
